buzzer_sched: RTL and testbench

Buzzer scheduler that shares the single buzzer output between `NREQ` requesters (proximity alert, key click, timer alarm). Each requester asks for a beep pattern of on-time, off-time and repeat count. The block grants the buzzer by fixed priority and plays the granted pattern cycle-accurately. Its output `oBUZ` drives the buzzer pin directly.

---
 rtl/buzzer_pkg.sv | 22 ++
 rtl/buz_pattern_timer.sv | 69 ++++++
 rtl/buzzer_sched.sv | 165 ++++++++++++++++
 tb/tb_buzzer_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_pkg
// Brief    : Shared FSM state encoding and default 100 MHz beep tick constants
//            for the buzzer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package buzzer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_ON   = 2'd1;
    localparam state_t c_ST_OFF  = 2'd2;

    // 50 ms alert beeps and a 1 ms key click at 100 MHz
    localparam int unsigned c_ALERT_ON  = 5_000_000;
    localparam int unsigned c_ALERT_OFF = 5_000_000;
    localparam int unsigned c_CLICK_ON  = 100_000;

endpackage
`default_nettype wire

// File: rtl/buz_pattern_timer.sv
`default_nettype none
// ============================================================================
// Module   : buz_pattern_timer
// Brief    : Shadow ON/OFF/REPEAT registers plus tick and period counters for
//            the pattern currently owning the buzzer.
// Revision : 1.0 - initial release
// ============================================================================
module buz_pattern_timer #(
    parameter int CNT_W = 24,
    parameter int REP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_phase_on,
    input  logic [CNT_W-1:0] i_on_ticks,
    input  logic [CNT_W-1:0] i_off_ticks,
    input  logic [REP_W-1:0] i_repeat,
    output logic             o_phase_end,
    output logic             o_last_period
);

    logic [CNT_W-1:0] r_on;
    logic [CNT_W-1:0] r_off;
    logic [REP_W-1:0] r_rep;
    logic [CNT_W-1:0] r_tick;
    logic [REP_W-1:0] r_period;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_eff;

    // A zero-length phase still lasts one cycle
    always_comb begin
        w_len = i_phase_on ? r_on : r_off;
        w_eff = (w_len == '0) ? CNT_W'(1) : w_len;
    end

    assign o_phase_end   = (r_tick >= w_eff);
    assign o_last_period = (r_rep != '0) && (r_period == r_rep);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_on     <= '0;
            r_off    <= '0;
            r_rep    <= '0;
            r_tick   <= '0;
            r_period <= '0;
        end else if (i_load) begin
            r_on     <= i_on_ticks;
            r_off    <= i_off_ticks;
            r_rep    <= i_repeat;
            r_tick   <= CNT_W'(1);
            r_period <= REP_W'(1);
        end else if (i_abort) begin
            r_tick   <= '0;
            r_period <= '0;
        end else if (i_start) begin
            r_tick <= CNT_W'(1);
            if (!i_phase_on && (r_period != '1)) begin
                r_period <= r_period + REP_W'(1);
            end
        end else if (r_tick != '0) begin
            r_tick <= r_tick + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/buzzer_sched.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sched
// Brief    : Fixed-priority buzzer scheduler playing one beep pattern at a time.
//            Define BUZZER_SCHED_PREEMPT_EN to let higher priority requests
//            preempt a pattern in progress.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_sched
    import buzzer_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 24,
    parameter int REP_W = 4
) (
    input  logic                    iCLK,
    input  logic                    iRSTN,
    input  logic [NREQ-1:0]         iREQ,
    input  logic [NREQ*CNT_W-1:0]   iON_TICKS,
    input  logic [NREQ*CNT_W-1:0]   iOFF_TICKS,
    input  logic [NREQ*REP_W-1:0]   iREPEAT,
    output logic                    oBUZ,
    output logic                    oBUSY,
    output logic [$clog2(NREQ)-1:0] oOWNER,
    output logic [NREQ-1:0]         oDONE
);

    localparam int c_OW = $clog2(NREQ);

    state_t            r_state;
    logic              r_buz;
    logic              r_busy;
    logic [c_OW-1:0]   r_owner;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_armed;

    logic [NREQ-1:0]   w_elig;
    logic              w_any;
    logic [c_OW-1:0]   w_win;
    logic              w_own_req;
    logic              w_active;
    logic              w_abort;
    logic              w_preempt;
    logic              w_complete;
    logic              w_load;
    logic              w_start;
    logic              w_phase_end;
    logic              w_last;

    assign w_elig = iREQ & r_armed;

    always_comb begin
        w_any     = 1'b0;
        w_win     = '0;
        w_own_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_win = c_OW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_OW'(i)) begin
                w_own_req = iREQ[i];
            end
        end
    end

    assign w_active = (r_state == c_ST_ON) || (r_state == c_ST_OFF);
    assign w_abort  = w_active && !w_own_req;

`ifdef BUZZER_SCHED_PREEMPT_EN
    assign w_preempt = w_active && !w_abort && w_any && (w_win < r_owner);
`else
    assign w_preempt = 1'b0;
`endif

    // Abort and preemption both take precedence over a normal completion
    assign w_complete = (r_state == c_ST_OFF) && !w_abort && !w_preempt && w_phase_end && w_last;
    assign w_load     = ((r_state == c_ST_IDLE) && w_any) || w_preempt;
    assign w_start    = w_active && !w_abort && !w_preempt && w_phase_end && !w_complete;

    buz_pattern_timer #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) u_timer (
        .i_clk         (iCLK),
        .i_rstn        (iRSTN),
        .i_load        (w_load),
        .i_start       (w_start),
        .i_abort       (w_abort || w_complete),
        .i_phase_on    (r_state == c_ST_ON),
        .i_on_ticks    (iON_TICKS[int'(w_win)*CNT_W +: CNT_W]),
        .i_off_ticks   (iOFF_TICKS[int'(w_win)*CNT_W +: CNT_W]),
        .i_repeat      (iREPEAT[int'(w_win)*REP_W +: REP_W]),
        .o_phase_end   (w_phase_end),
        .o_last_period (w_last)
    );

    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            r_state <= c_ST_IDLE;
            r_buz   <= 1'b0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_done  <= '0;
            r_armed <= '1;
        end else begin
            // A request must be seen low once before its pattern can replay
            for (int i = 0; i < NREQ; i++) begin
                r_done[i] <= w_complete && (r_owner == c_OW'(i));
                if (!iREQ[i]) begin
                    r_armed[i] <= 1'b1;
                end else if (w_complete && (r_owner == c_OW'(i))) begin
                    r_armed[i] <= 1'b0;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ST_ON;
                        r_buz   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                    end
                end
                c_ST_ON, c_ST_OFF: begin
                    if (w_abort) begin
                        r_state <= c_ST_IDLE;
                        r_buz   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_preempt) begin
                        r_state <= c_ST_ON;
                        r_buz   <= 1'b1;
                        r_owner <= w_win;
                    end else if (w_phase_end) begin
                        if (r_state == c_ST_ON) begin
                            r_state <= c_ST_OFF;
                            r_buz   <= 1'b0;
                        end else if (w_last) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_ST_ON;
                            r_buz   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_buz   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oBUZ   = r_buz;
    assign oBUSY  = r_busy;
    assign oOWNER = r_owner;
    assign oDONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_sched
// Brief    : Directed self-checking bench for buzzer_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_sched;

    localparam int NREQ  = 3;
    localparam int CNT_W = 24;
    localparam int REP_W = 4;

    logic                  iCLK;
    logic                  iRSTN;
    logic [NREQ-1:0]       iREQ;
    logic [NREQ*CNT_W-1:0] iON_TICKS;
    logic [NREQ*CNT_W-1:0] iOFF_TICKS;
    logic [NREQ*REP_W-1:0] iREPEAT;
    logic                  oBUZ;
    logic                  oBUSY;
    logic [1:0]            oOWNER;
    logic [NREQ-1:0]       oDONE;

    int n_checks = 0;
    int n_fail   = 0;

    buzzer_sched #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .iCLK       (iCLK),
        .iRSTN      (iRSTN),
        .iREQ       (iREQ),
        .iON_TICKS  (iON_TICKS),
        .iOFF_TICKS (iOFF_TICKS),
        .iREPEAT    (iREPEAT),
        .oBUZ       (oBUZ),
        .oBUSY      (oBUSY),
        .oOWNER     (oOWNER),
        .oDONE      (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic cyc();
        @(negedge iCLK);
    endtask

    task automatic set_pat(input int i, input int on, input int off, input int rep);
        iON_TICKS[i*CNT_W +: CNT_W]  = CNT_W'(on);
        iOFF_TICKS[i*CNT_W +: CNT_W] = CNT_W'(off);
        iREPEAT[i*REP_W +: REP_W]    = REP_W'(rep);
    endtask

    task automatic quiesce();
        iREQ = '0;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        cyc();
        n_checks++;
        if ({oBUZ, oBUSY, oOWNER, oDONE} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got buz=%b busy=%b owner=%0d done=%b expected all 0", oBUZ, oBUSY, oOWNER, oDONE);
        end
        iRSTN = 1'b1;
        cyc();
        n_checks++;
        if ({oBUZ, oBUSY, oOWNER, oDONE} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release: got buz=%b busy=%b owner=%0d done=%b expected all 0", oBUZ, oBUSY, oOWNER, oDONE);
        end
    endtask

    task automatic test_single();
        logic [9:0] exp_buz;
        exp_buz = 10'b1110011100;
        set_pat(0, 3, 2, 2);
        iREQ = 3'b001;
        for (int j = 0; j < 10; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== exp_buz[9-j] || oBUSY !== 1'b1 || oOWNER !== 2'd0 || oDONE !== 3'b000) begin
                n_fail++;
                $display("FAIL single_play[%0d]: got buz=%b busy=%b owner=%0d done=%b expected buz=%b busy=1 owner=0 done=000",
                         j, oBUZ, oBUSY, oOWNER, oDONE, exp_buz[9-j]);
            end
        end
        cyc();
        n_checks++;
        if (oDONE !== 3'b001 || oBUSY !== 1'b0 || oBUZ !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b busy=%b buz=%b expected done=001 busy=0 buz=0", oDONE, oBUSY, oBUZ);
        end
        for (int j = 0; j < 6; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 3'b000) begin
                n_fail++;
                $display("FAIL single_no_replay[%0d]: got buz=%b busy=%b done=%b expected 0 0 000", j, oBUZ, oBUSY, oDONE);
            end
        end
        quiesce();
    endtask

    task automatic test_priority();
        logic [6:0] exp_buz;
        logic [1:0] exp_own [7];
        logic [2:0] exp_done [7];
        exp_buz  = 7'b1100100;
        exp_own  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        exp_done = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};
        set_pat(1, 2, 1, 1);
        set_pat(2, 1, 1, 1);
        iREQ = 3'b110;
        for (int j = 0; j < 7; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== exp_buz[6-j] || oOWNER !== exp_own[j] || oDONE !== exp_done[j]) begin
                n_fail++;
                $display("FAIL priority[%0d]: got buz=%b owner=%0d done=%b expected buz=%b owner=%0d done=%b",
                         j, oBUZ, oOWNER, oDONE, exp_buz[6-j], exp_own[j], exp_done[j]);
            end
        end
        quiesce();
    endtask

    task automatic test_abort();
        set_pat(0, 10, 1, 0);
        iREQ = 3'b001;
        for (int j = 0; j < 4; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== 1'b1 || oBUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_on[%0d]: got buz=%b busy=%b expected 1 1", j, oBUZ, oBUSY);
            end
        end
        iREQ = 3'b000;
        for (int j = 0; j < 3; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_idle[%0d]: got buz=%b busy=%b done=%b expected 0 0 000", j, oBUZ, oBUSY, oDONE);
            end
        end
    endtask

    task automatic test_preempt();
        set_pat(2, 8, 2, 1);
        set_pat(0, 2, 1, 1);
        iREQ = 3'b100;
        for (int j = 0; j < 3; j++) begin
            cyc();
            n_checks++;
            if (oOWNER !== 2'd2 || oBUZ !== 1'b1) begin
                n_fail++;
                $display("FAIL preempt_start[%0d]: got owner=%0d buz=%b expected owner=2 buz=1", j, oOWNER, oBUZ);
            end
        end
        iREQ = 3'b101;
`ifdef BUZZER_SCHED_PREEMPT_EN
        begin
            logic [3:0] exp_buz;
            logic [2:0] exp_done [4];
            exp_buz  = 4'b1100;
            exp_done = '{3'b000, 3'b000, 3'b000, 3'b001};
            for (int j = 0; j < 4; j++) begin
                cyc();
                n_checks++;
                if (oOWNER !== 2'd0 || oBUZ !== exp_buz[3-j] || oDONE !== exp_done[j]) begin
                    n_fail++;
                    $display("FAIL preempt_take[%0d]: got owner=%0d buz=%b done=%b expected owner=0 buz=%b done=%b",
                             j, oOWNER, oBUZ, oDONE, exp_buz[3-j], exp_done[j]);
                end
            end
        end
`else
        begin
            logic [11:0] exp_buz;
            logic [1:0]  exp_own [12];
            logic [2:0]  exp_done [12];
            exp_buz  = 12'b111110001100;
            exp_own  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
            exp_done = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                         3'b000, 3'b000, 3'b000, 3'b001};
            for (int j = 0; j < 12; j++) begin
                cyc();
                n_checks++;
                if (oOWNER !== exp_own[j] || oBUZ !== exp_buz[11-j] || oDONE !== exp_done[j]) begin
                    n_fail++;
                    $display("FAIL preempt_wait[%0d]: got owner=%0d buz=%b done=%b expected owner=%0d buz=%b done=%b",
                             j, oOWNER, oBUZ, oDONE, exp_own[j], exp_buz[11-j], exp_done[j]);
                end
            end
        end
`endif
        quiesce();
    endtask

    task automatic test_zero_ticks();
        logic [6:0] exp_buz;
        set_pat(0, 0, 0, 3);
        exp_buz = 7'b1010100;
        iREQ = 3'b001;
        for (int j = 0; j < 7; j++) begin
            cyc();
            n_checks++;
            if (oBUZ !== exp_buz[6-j] || oDONE !== ((j == 6) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL zero_ticks[%0d]: got buz=%b done=%b expected buz=%b done=%b",
                         j, oBUZ, oDONE, exp_buz[6-j], (j == 6) ? 3'b001 : 3'b000);
            end
        end
        quiesce();
    endtask

    task automatic test_reset_mid();
        set_pat(1, 10, 1, 0);
        iREQ = 3'b010;
        cyc();
        cyc();
        n_checks++;
        if (oBUZ !== 1'b1 || oOWNER !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_play: got buz=%b owner=%0d expected buz=1 owner=1", oBUZ, oOWNER);
        end
        iRSTN = 1'b0;
        cyc();
        n_checks++;
        if ({oBUZ, oBUSY, oOWNER, oDONE} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got buz=%b busy=%b owner=%0d done=%b expected all 0", oBUZ, oBUSY, oOWNER, oDONE);
        end
        iRSTN = 1'b1;
        cyc();
        n_checks++;
        if (oBUZ !== 1'b1 || oBUSY !== 1'b1 || oOWNER !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got buz=%b busy=%b owner=%0d expected 1 1 1", oBUZ, oBUSY, oOWNER);
        end
        quiesce();
    endtask

    initial begin
        iRSTN      = 1'b0;
        iREQ       = '0;
        iON_TICKS  = '0;
        iOFF_TICKS = '0;
        iREPEAT    = '0;
        cyc();
        test_reset();
        test_single();
        test_priority();
        test_abort();
        test_preempt();
        test_zero_ticks();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
